// File: rtl/hcp_gmii_write_pkg.sv
// Shared constants, state encoding and word helper for the GMII-to-HCP receive FIFO writer.
package hcp_gmii_write_pkg;

    localparam int unsigned DELIM_BIT     = 8;
    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam int unsigned MAX_LEN_DEF   = 1522;

    typedef enum logic [2:0] {
        IDLE_S,
        PREAMBLE_S,
        FIRST_S,
        HEAD_S,
        TRANS_S,
        DISCARD_S
    } state_t;

    function automatic logic [DELIM_BIT:0] mk_word(input logic delim, input logic [7:0] data);
        logic [DELIM_BIT:0] w;
        w            = {1'b0, data};
        w[DELIM_BIT] = delim;
        return w;
    endfunction

endpackage

// File: rtl/hcp_gmii_in_reg.sv
// Stage-0 register for the GMII receive signals; isolated so the flops can be packed into IOBs.
module hcp_gmii_in_reg (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_dv,
    input  logic [7:0] iv_rxd,
    input  logic       i_er,
    output logic       o_dv,
    output logic [7:0] ov_rxd,
    output logic       o_er
);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_dv   <= 1'b0;
            ov_rxd <= 8'h00;
            o_er   <= 1'b0;
        end else begin
            o_dv   <= i_dv;
            ov_rxd <= iv_rxd;
            o_er   <= i_er;
        end
    end

endmodule

// File: rtl/hcp_gmii_write.sv
// Strips preamble/SFD from GMII receive frames and writes whole, delimited frames into the
// 9-bit receive FIFO; runt, oversize, bad-preamble and no-space frames are filtered.
module hcp_gmii_write
    import hcp_gmii_write_pkg::*;
#(
    parameter int unsigned MAX_LEN    = MAX_LEN_DEF,
    parameter int unsigned FIFO_DEPTH = 2048,
    parameter int unsigned USEDW_W    = 12
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_gmii_rx_dv,
    input  logic [7:0]         iv_gmii_rxd,
    input  logic               i_gmii_rx_er,
    input  logic [USEDW_W-1:0] iv_fifo_usedw,
    output logic [8:0]         ov_data,
    output logic               o_data_wr,
    output logic               o_fifo_overflow_pulse,
    output logic               o_frame_error_pulse,
    output logic               o_gmii_rx_er_pulse
);

    localparam int unsigned        CNT_W       = $clog2(MAX_LEN + 1);
    localparam logic [USEDW_W-1:0] SPACE_LIMIT = USEDW_W'(FIFO_DEPTH - MAX_LEN);
    localparam logic [CNT_W-1:0]   CNT_MAX     = CNT_W'(MAX_LEN);

    logic       w_dv;
    logic [7:0] w_rxd;
    logic       w_er;

    state_t           r_state;
    logic [7:0]       r_hold;
    logic [CNT_W-1:0] r_cnt;

    hcp_gmii_in_reg u_in_reg (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_dv   (i_gmii_rx_dv),
        .iv_rxd (iv_gmii_rxd),
        .i_er   (i_gmii_rx_er),
        .o_dv   (w_dv),
        .ov_rxd (w_rxd),
        .o_er   (w_er)
    );

    // One byte is held back so the tail delimiter can be set once dv falls.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state               <= IDLE_S;
            r_hold                <= 8'h00;
            r_cnt                 <= '0;
            ov_data               <= 9'h000;
            o_data_wr             <= 1'b0;
            o_fifo_overflow_pulse <= 1'b0;
            o_frame_error_pulse   <= 1'b0;
            o_gmii_rx_er_pulse    <= 1'b0;
        end else begin
            o_data_wr             <= 1'b0;
            o_fifo_overflow_pulse <= 1'b0;
            o_frame_error_pulse   <= 1'b0;
            o_gmii_rx_er_pulse    <= w_er && ((r_state == FIRST_S) || (r_state == HEAD_S) ||
                                              (r_state == TRANS_S));
            case (r_state)
                IDLE_S, PREAMBLE_S: begin
                    if (!w_dv) begin
                        r_state <= IDLE_S;
                    end else if (w_rxd == PREAMBLE_BYTE) begin
                        r_state <= PREAMBLE_S;
                    end else if (w_rxd == SFD_BYTE) begin
                        if (iv_fifo_usedw > SPACE_LIMIT) begin
                            r_state               <= DISCARD_S;
                            o_fifo_overflow_pulse <= 1'b1;
                        end else begin
                            r_state <= FIRST_S;
                            r_cnt   <= '0;
                        end
                    end else begin
                        r_state             <= DISCARD_S;
                        o_frame_error_pulse <= 1'b1;
                    end
                end
                FIRST_S: begin
                    if (w_dv) begin
                        r_hold  <= w_rxd;
                        r_cnt   <= CNT_W'(1);
                        r_state <= HEAD_S;
                    end else begin
                        r_state             <= IDLE_S;
                        o_frame_error_pulse <= 1'b1;
                    end
                end
                HEAD_S: begin
                    if (w_dv) begin
                        ov_data   <= mk_word(1'b1, r_hold);
                        o_data_wr <= 1'b1;
                        r_hold    <= w_rxd;
                        r_cnt     <= CNT_W'(2);
                        r_state   <= TRANS_S;
                    end else begin
                        r_state             <= IDLE_S;
                        o_frame_error_pulse <= 1'b1;
                    end
                end
                TRANS_S: begin
                    o_data_wr <= 1'b1;
                    if (!w_dv) begin
                        ov_data <= mk_word(1'b1, r_hold);
                        r_state <= IDLE_S;
                    end else if (r_cnt >= CNT_MAX) begin
                        ov_data             <= mk_word(1'b1, r_hold);
                        o_frame_error_pulse <= 1'b1;
                        r_state             <= DISCARD_S;
                    end else begin
                        ov_data <= mk_word(1'b0, r_hold);
                        r_hold  <= w_rxd;
                        r_cnt   <= r_cnt + CNT_W'(1);
                    end
                end
                DISCARD_S: begin
                    if (!w_dv) begin
                        r_state <= IDLE_S;
                    end
                end
                default: r_state <= IDLE_S;
            endcase
        end
    end

endmodule

// File: tb/tb_hcp_gmii_write.sv
// Directed self-checking bench for hcp_gmii_write: frames are driven on the GMII pins and every
// FIFO write and pulse is collected at the falling edge and compared with hand-built expectations.
module tb_hcp_gmii_write;

    localparam int unsigned MAX_LEN    = 1522;
    localparam int unsigned FIFO_DEPTH = 2048;
    localparam int unsigned USEDW_W    = 12;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               rx_dv = 1'b0;
    logic [7:0]         rxd = 8'h00;
    logic               rx_er = 1'b0;
    logic [USEDW_W-1:0] usedw = '0;
    logic [8:0]         data;
    logic               data_wr;
    logic               ovf_pulse;
    logic               ferr_pulse;
    logic               rxer_pulse;

    int n_checks = 0;
    int n_fail   = 0;

    logic [8:0] cap_q[$];
    logic [8:0] exp_q[$];
    int n_wr   = 0;
    int n_ovf  = 0;
    int n_ferr = 0;
    int n_rxer = 0;

    hcp_gmii_write #(
        .MAX_LEN    (MAX_LEN),
        .FIFO_DEPTH (FIFO_DEPTH),
        .USEDW_W    (USEDW_W)
    ) dut (
        .i_clk                 (clk),
        .i_rst                 (rst),
        .i_gmii_rx_dv          (rx_dv),
        .iv_gmii_rxd           (rxd),
        .i_gmii_rx_er          (rx_er),
        .iv_fifo_usedw         (usedw),
        .ov_data               (data),
        .o_data_wr             (data_wr),
        .o_fifo_overflow_pulse (ovf_pulse),
        .o_frame_error_pulse   (ferr_pulse),
        .o_gmii_rx_er_pulse    (rxer_pulse)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (data_wr) begin
            cap_q.push_back(data);
            n_wr++;
        end
        if (ovf_pulse)  n_ovf++;
        if (ferr_pulse) n_ferr++;
        if (rxer_pulse) n_rxer++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: run did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input logic dv, input logic [7:0] d, input logic er);
        rx_dv = dv;
        rxd   = d;
        rx_er = er;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 8'h00, 1'b0);
    endtask

    task automatic send_pre();
        for (int i = 0; i < 7; i++) tick(1'b1, 8'h55, 1'b0);
        tick(1'b1, 8'hD5, 1'b0);
    endtask

    task automatic send_payload(input int start, input int n, input int er_from, input int er_len);
        for (int i = 0; i < n; i++)
            tick(1'b1, 8'(start + i), (i >= er_from) && (i < er_from + er_len));
    endtask

    // Expected FIFO words for a good frame of n incrementing bytes, truncated at MAX_LEN.
    task automatic exp_frame(input int start, input int n);
        int m;
        m = (n > int'(MAX_LEN)) ? int'(MAX_LEN) : n;
        for (int i = 0; i < m; i++)
            exp_q.push_back({(i == 0) || (i == m - 1), 8'(start + i)});
    endtask

    task automatic clear_obs();
        cap_q.delete();
        exp_q.delete();
        n_ovf  = 0;
        n_ferr = 0;
        n_rxer = 0;
    endtask

    task automatic check_frames(input string tag);
        int n_bad;
        n_bad = 0;
        check_eq({tag, "_len"}, cap_q.size(), exp_q.size());
        for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++)
            if (cap_q[i] !== exp_q[i]) n_bad++;
        check_eq({tag, "_words_bad"}, n_bad, 0);
    endtask

    initial begin
        int wr_at_rst;

        // Reset state
        idle(3);
        check_eq("rst_data", data, 0);
        check_eq("rst_wr", data_wr, 0);
        check_eq("rst_ovf", ovf_pulse, 0);
        check_eq("rst_ferr", ferr_pulse, 0);
        check_eq("rst_rxer", rxer_pulse, 0);
        rst = 1'b0;
        idle(2);
        clear_obs();

        // Normal 64-byte frame
        send_pre();
        send_payload(0, 64, 0, 0);
        idle(6);
        exp_frame(0, 64);
        check_frames("normal");
        check_eq("normal_ferr", n_ferr, 0);
        check_eq("normal_ovf", n_ovf, 0);
        check_eq("normal_rxer", n_rxer, 0);
        clear_obs();

        // Back-to-back frames with a single dv-low cycle between them
        send_pre();
        send_payload(0, 64, 0, 0);
        idle(1);
        send_pre();
        send_payload(8'h40, 64, 0, 0);
        idle(6);
        exp_frame(0, 64);
        exp_frame(8'h40, 64);
        check_frames("b2b");
        check_eq("b2b_ferr", n_ferr, 0);
        clear_obs();

        // Bad preamble byte
        tick(1'b1, 8'h55, 1'b0);
        tick(1'b1, 8'h54, 1'b0);
        tick(1'b1, 8'h55, 1'b0);
        tick(1'b1, 8'hD5, 1'b0);
        send_payload(0, 10, 0, 0);
        idle(6);
        check_eq("badpre_len", cap_q.size(), 0);
        check_eq("badpre_ferr", n_ferr, 1);
        clear_obs();

        // One-byte runt
        send_pre();
        send_payload(8'hA0, 1, 0, 0);
        idle(6);
        check_eq("runt_len", cap_q.size(), 0);
        check_eq("runt_ferr", n_ferr, 1);
        clear_obs();

        // No FIFO space by one word, then exactly enough
        usedw = USEDW_W'(FIFO_DEPTH - MAX_LEN + 1);
        send_pre();
        send_payload(0, 64, 0, 0);
        idle(6);
        check_eq("nospace_len", cap_q.size(), 0);
        check_eq("nospace_ovf", n_ovf, 1);
        check_eq("nospace_ferr", n_ferr, 0);
        clear_obs();
        usedw = USEDW_W'(FIFO_DEPTH - MAX_LEN);
        send_pre();
        send_payload(8'h10, 64, 0, 0);
        idle(6);
        exp_frame(8'h10, 64);
        check_frames("space_edge");
        check_eq("space_edge_ovf", n_ovf, 0);
        clear_obs();
        usedw = '0;

        // Oversize frame is truncated to MAX_LEN with a tail delimiter
        send_pre();
        send_payload(0, 1600, 0, 0);
        idle(6);
        exp_frame(0, 1600);
        check_frames("oversize");
        check_eq("oversize_ferr", n_ferr, 1);
        if (cap_q.size() > 0)
            check_eq("oversize_tail", cap_q[cap_q.size() - 1], {1'b1, 8'(MAX_LEN - 1)});
        clear_obs();

        // rx_er held for three cycles mid-frame
        send_pre();
        send_payload(0, 64, 20, 3);
        idle(6);
        exp_frame(0, 64);
        check_frames("rxer");
        check_eq("rxer_pulses", n_rxer, 3);
        clear_obs();

        // Reset after ten payload bytes, then a clean frame
        send_pre();
        send_payload(0, 10, 0, 0);
        rst = 1'b1;
        tick(1'b1, 8'h0A, 1'b0);
        check_eq("midrst_wr", data_wr, 0);
        wr_at_rst = n_wr;
        idle(2);
        rst = 1'b0;
        idle(4);
        check_eq("midrst_nowr", n_wr, wr_at_rst);
        clear_obs();
        send_pre();
        send_payload(8'h20, 64, 0, 0);
        idle(6);
        exp_frame(8'h20, 64);
        check_frames("postrst");
        check_eq("postrst_ferr", n_ferr, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hcp_gmii_write.md
Name: hcp_gmii_write

Overview:
Producer-side counterpart of the HCP interface input FIFO reader.
- Samples the GMII receive interface.
- Strips preamble and SFD.
- Writes each frame into the 9-bit receive FIFO as a delimited byte stream: bit8=1 on the first and last byte, bit8=0 on middle bytes.
- Guarantees the reader only sees whole, well-formed frames. Space is checked before a frame starts, and runt, oversize and bad-preamble frames are filtered.

Parameters:
MAX_LEN, 1522, maximum frame bytes written (post-SFD, FCS included); longer frames are truncated.
FIFO_DEPTH, 2048, depth in words of the downstream FIFO.
USEDW_W, 12, width of the FIFO used-words input.

Ports:
i_clk  input  1  system clock; GMII rx signals are synchronous to it.
i_rst  input  1  synchronous reset, active-high.
i_gmii_rx_dv  input  1  GMII receive data valid.
iv_gmii_rxd  input  8  GMII receive data.
i_gmii_rx_er  input  1  GMII receive error.
iv_fifo_usedw  input  USEDW_W  FIFO occupied words.
ov_data  output  9  FIFO write data: {delimiter, byte}.
o_data_wr  output  1  FIFO write enable.
o_fifo_overflow_pulse  output  1  1-cycle pulse: frame dropped for lack of FIFO space.
o_frame_error_pulse  output  1  1-cycle pulse: runt, oversize or bad preamble.
o_gmii_rx_er_pulse  output  1  1-cycle pulse: rx_er seen inside a frame.

Behaviour:
Clocking and reset
- One clock. All logic is synchronous to i_clk; reset is sampled only on the i_clk edge.
- Reset values: all outputs 0, state IDLE_S, hold register and byte counter 0.
- Stage 0 registers dv/rxd/er on every edge; all decisions use these registered copies.

State machine
- IDLE_S: o_data_wr=0. When r_dv=1 → PREAMBLE_S and evaluate the current byte as preamble.
- PREAMBLE_S:
  - r_dv=0 → IDLE_S, silently.
  - r_rxd=0x55 → stay.
  - r_rxd=0xD5 (SFD) → space check, then FIRST_S or DISCARD_S (below).
  - Any other byte → DISCARD_S, pulse o_frame_error_pulse.
- Space check at SFD:
  - If iv_fifo_usedw > FIFO_DEPTH-MAX_LEN → DISCARD_S, pulse o_fifo_overflow_pulse.
  - Otherwise → FIRST_S with counter=0.
- FIRST_S:
  - First post-SFD byte with r_dv=1 → capture into hold, counter=1, → HEAD_S.
  - r_dv=0 → IDLE_S, pulse o_frame_error_pulse (empty frame).
- HEAD_S (hold holds byte 1, nothing written yet):
  - r_dv=1 → write {1,hold}, hold←r_rxd, counter=2, → TRANS_S.
  - r_dv=0 → discard hold, pulse o_frame_error_pulse (runt: a 1-byte frame cannot be delimited), → IDLE_S.
- TRANS_S:
  - r_dv=1 and counter<MAX_LEN → write {0,hold}, hold←r_rxd, counter+1.
  - r_dv=1 and counter==MAX_LEN → write {1,hold} as tail, pulse o_frame_error_pulse, → DISCARD_S. Exactly MAX_LEN words are written.
  - r_dv=0 → write {1,hold} as tail, → IDLE_S.
- DISCARD_S: o_data_wr=0 until r_dv=0, then → IDLE_S.

Latency and timing
- Byte k is written on the edge at which byte k+1 is processed: pin-to-FIFO latency is 2 cycles plus 1 byte time.
- Tail is written 2 cycles after dv deasserts on the pins.

Error and boundary handling
- r_er=1 while in FIRST_S, HEAD_S or TRANS_S → o_gmii_rx_er_pulse for each such cycle; the frame is still passed unmodified.
- Inter-frame gap of a single dv-low cycle is legal: the tail write and the IDLE_S→PREAMBLE_S transition occur on consecutive edges without loss.
- Space is checked only at SFD. Mid-frame writes always fit, because a frame never exceeds MAX_LEN words.
- Reset mid-frame: no further writes; a partial frame already in the FIFO is the reader's underflow/error case and is not repaired here.
- A frame already in progress at reset release (dv high) is seen in IDLE_S as starting mid-frame. It enters PREAMBLE_S; a non-0x55/0xD5 byte sends it to DISCARD_S with an error pulse.

Decomposition:
- Shared hcp package:
  - delimiter bit index 8.
  - PREAMBLE byte 0x55 and SFD 0xD5.
  - state encodings.
  - MAX_LEN default.
- One natural sub-module: hcp_gmii_in_reg, the stage-0 input register for dv/rxd/er; kept separate so IOB packing is controllable.
- Frame FSM, hold register and counter stay in hcp_gmii_write.

Test Plan:
- Normal frame: 7×0x55, 0xD5, then 64 bytes 0x00..0x3F, usedw=0 → 64 writes: {1,00}, {0,01}..{0,3E}, {1,3F}; no pulses.
- Back-to-back frames: two 64-byte frames separated by 1 dv-low cycle → 128 writes, both tails correct, no loss.
- Bad input:
  - Preamble 0x55,0x54,... → zero writes, one o_frame_error_pulse.
  - 1-byte frame after SFD → zero writes, one o_frame_error_pulse.
- Space: usedw=FIFO_DEPTH-MAX_LEN+1 at SFD → zero writes, one o_fifo_overflow_pulse. Same frame with usedw=FIFO_DEPTH-MAX_LEN → accepted.
- Oversize: 1600-byte frame → exactly 1522 writes, last one bit8=1, one o_frame_error_pulse, then nothing until the next frame.
- Reset and rx_er:
  - i_rst asserted after 10 payload bytes → o_data_wr=0 from the next edge; next clean frame is written correctly.
  - rx_er held for 3 cycles mid-frame → 3 o_gmii_rx_er_pulse cycles, data unchanged.
